// File: rtl/alu_decoder_if.sv
// Decode request and registered result bundle between the control path and the ALU decoder.
interface alu_decoder_if;
  logic       en;
  logic [6:0] opcode;
  logic [2:0] func3;
  logic [6:0] func7;
  logic [3:0] alu_control;
  logic       illegal;

  modport master (
    output en, opcode, func3, func7,
    input  alu_control, illegal
  );

  modport slave (
    input  en, opcode, func3, func7,
    output alu_control, illegal
  );
endinterface

// File: rtl/alu_decoder.sv
// Registered RV32I ALU-operation decoder: opcode/func3/func7 to a 4-bit ALU select plus illegal flag.
module alu_decoder (
  input  logic          clk,
  input  logic          rst,
  alu_decoder_if.slave  bus
);

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  alu_op_e alu_op_p0;
  logic    illegal_p0;
  logic    f7_zero;
  logic    f7_alt;
  alu_op_e alu_op_p1;
  logic    illegal_p1;

  assign f7_zero = (bus.func7 == 7'b0000000);
  assign f7_alt  = (bus.func7 == 7'b0100000);

  // Stage p0: combinational decode of the presented encoding
  always_comb begin
    alu_op_p0  = ALU_ADD;
    illegal_p0 = 1'b0;
    case (bus.opcode)
      OPC_OP: begin
        if (!(f7_zero || f7_alt)) begin
          illegal_p0 = 1'b1;
        end else begin
          case (bus.func3)
            3'b000: alu_op_p0 = f7_alt ? ALU_SUB : ALU_ADD;
            3'b001: alu_op_p0 = ALU_SLL;
            3'b010: alu_op_p0 = ALU_SLT;
            3'b011: alu_op_p0 = ALU_SLTU;
            3'b100: alu_op_p0 = ALU_XOR;
            3'b101: alu_op_p0 = f7_alt ? ALU_SRA : ALU_SRL;
            3'b110: alu_op_p0 = ALU_OR;
            default: alu_op_p0 = ALU_AND;
          endcase
          // Only ADD/SUB and SRL/SRA have an alternate func7 form
          if (f7_alt && (bus.func3 != 3'b000) && (bus.func3 != 3'b101)) begin
            illegal_p0 = 1'b1;
          end
        end
      end
      OPC_OP_IMM: begin
        case (bus.func3)
          3'b000: alu_op_p0 = ALU_ADD;
          3'b001: begin
            alu_op_p0  = ALU_SLL;
            illegal_p0 = !f7_zero;
          end
          3'b010: alu_op_p0 = ALU_SLT;
          3'b011: alu_op_p0 = ALU_SLTU;
          3'b100: alu_op_p0 = ALU_XOR;
          3'b101: begin
            alu_op_p0  = f7_alt ? ALU_SRA : ALU_SRL;
            illegal_p0 = !(f7_zero || f7_alt);
          end
          3'b110: alu_op_p0 = ALU_OR;
          default: alu_op_p0 = ALU_AND;
        endcase
      end
      OPC_LOAD, OPC_STORE, OPC_JAL, OPC_AUIPC: alu_op_p0 = ALU_ADD;
      OPC_BRANCH: begin
        case (bus.func3[2:1])
          2'b00: alu_op_p0 = ALU_SUB;
          2'b10: alu_op_p0 = ALU_SLT;
          2'b11: alu_op_p0 = ALU_SLTU;
          default: illegal_p0 = 1'b1;
        endcase
      end
      OPC_JALR: illegal_p0 = (bus.func3 != 3'b000);
      OPC_LUI:  alu_op_p0 = ALU_PASS_B;
      default:  illegal_p0 = 1'b1;
    endcase
    // Illegal encodings always present a benign ADD to the ALU
    if (illegal_p0) begin
      alu_op_p0 = ALU_ADD;
    end
  end

  // Stage p1: registered outputs, held while en is low
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_op_p1  <= ALU_ADD;
      illegal_p1 <= 1'b0;
    end else if (bus.en) begin
      alu_op_p1  <= alu_op_p0;
      illegal_p1 <= illegal_p0;
    end
  end

  assign bus.alu_control = alu_op_p1;
  assign bus.illegal     = illegal_p1;

endmodule

// File: tb/tb_alu_decoder.sv
// Self-checking bench for alu_decoder: directed plan steps followed by randomized encodings vs. a reference model.
module tb_alu_decoder;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  alu_decoder_if bus ();

  alu_decoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Base op per func3 for OP/OP-IMM; alternate form is base+1 (ADD->SUB, SRL->SRA)
  localparam int R_TAB [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
  // Branch comparison op per func3; -1 marks an illegal branch
  localparam int B_TAB [8] = '{1, 1, -1, -1, 3, 3, 4, 4};

  logic [3:0] mdl_ctl;
  logic       mdl_ill;

  function automatic void ref_decode(input logic [6:0] op, input logic [2:0] f3,
                                     input logic [6:0] f7,
                                     output logic [3:0] c, output logic il);
    int v;
    v  = 0;
    il = 1'b0;
    if (op == 7'b0110011) begin
      if (f7 == 7'd0) v = R_TAB[f3];
      else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) v = R_TAB[f3] + 1;
      else il = 1'b1;
    end else if (op == 7'b0010011) begin
      if (f3 == 3'd1) begin
        v = 2;
        il = (f7 != 7'd0);
      end else if (f3 == 3'd5) begin
        if (f7 == 7'd0) v = 6;
        else if (f7 == 7'h20) v = 7;
        else il = 1'b1;
      end else v = R_TAB[f3];
    end else if (op == 7'b0000011 || op == 7'b0100011 || op == 7'b1101111 || op == 7'b0010111) begin
      v = 0;
    end else if (op == 7'b1100011) begin
      if (B_TAB[f3] < 0) il = 1'b1;
      else v = B_TAB[f3];
    end else if (op == 7'b1100111) begin
      il = (f3 != 3'd0);
    end else if (op == 7'b0110111) begin
      v = 10;
    end else begin
      il = 1'b1;
    end
    if (il) v = 0;
    c = v[3:0];
  endfunction

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model, sample 1 time unit after the edge.
  // exp_c < 0 means only the model is compared; otherwise the given constants are checked too.
  task automatic step(input string tag, input logic r, input logic e, input logic [6:0] op,
                      input logic [2:0] f3, input logic [6:0] f7,
                      input int exp_c, input int exp_i);
    logic [3:0] c;
    logic       il;
    rst        = r;
    bus.en     = e;
    bus.opcode = op;
    bus.func3  = f3;
    bus.func7  = f7;
    @(posedge clk);
    if (r) begin
      mdl_ctl = 4'd0;
      mdl_ill = 1'b0;
    end else if (e) begin
      ref_decode(op, f3, f7, c, il);
      mdl_ctl = c;
      mdl_ill = il;
    end
    #1;
    check({tag, ".model_ctl"}, bus.alu_control, mdl_ctl);
    check({tag, ".model_ill"}, {3'b0, bus.illegal}, {3'b0, mdl_ill});
    if (exp_c >= 0) begin
      check({tag, ".ctl"}, bus.alu_control, exp_c[3:0]);
      check({tag, ".ill"}, {3'b0, bus.illegal}, exp_i[3:0]);
    end
  endtask

  localparam logic [6:0] OPS [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                     7'b1100011, 7'b1101111, 7'b1100111, 7'b0010111,
                                     7'b0110111};

  initial begin
    logic [6:0] op;
    logic [6:0] f7;
    logic [2:0] f3;
    int         sel;
    int         rt_exp [8];
    errors  = 0;
    checks  = 0;
    mdl_ctl = 4'd0;
    mdl_ill = 1'b0;
    rt_exp  = '{0, 2, 3, 4, 5, 6, 8, 9};

    step("rst0", 1'b1, 1'b1, 7'b0110011, 3'd0, 7'h20, 0, 0);
    step("rst1", 1'b1, 1'b1, 7'b0110011, 3'd0, 7'h20, 0, 0);
    step("sub_after_rst", 1'b0, 1'b1, 7'b0110011, 3'd0, 7'h20, 1, 0);

    for (int i = 0; i < 8; i++) begin
      step($sformatf("r_f3_%0d", i), 1'b0, 1'b1, 7'b0110011, i[2:0], 7'h00, rt_exp[i], 0);
    end
    step("r_sub", 1'b0, 1'b1, 7'b0110011, 3'd0, 7'h20, 1, 0);
    step("r_sra", 1'b0, 1'b1, 7'b0110011, 3'd5, 7'h20, 7, 0);
    step("r_or_alt", 1'b0, 1'b1, 7'b0110011, 3'd6, 7'h20, 0, 1);
    step("r_bad_f7", 1'b0, 1'b1, 7'b0110011, 3'd0, 7'h01, 0, 1);

    step("i_srai", 1'b0, 1'b1, 7'b0010011, 3'd5, 7'h20, 7, 0);
    step("i_srli", 1'b0, 1'b1, 7'b0010011, 3'd5, 7'h00, 6, 0);
    step("i_slli_alt", 1'b0, 1'b1, 7'b0010011, 3'd1, 7'h20, 0, 1);
    step("i_addi_f7", 1'b0, 1'b1, 7'b0010011, 3'd0, 7'h7f, 0, 0);

    step("beq", 1'b0, 1'b1, 7'b1100011, 3'd0, 7'h00, 1, 0);
    step("blt", 1'b0, 1'b1, 7'b1100011, 3'd4, 7'h00, 3, 0);
    step("bgeu", 1'b0, 1'b1, 7'b1100011, 3'd7, 7'h00, 4, 0);
    step("br_010", 1'b0, 1'b1, 7'b1100011, 3'd2, 7'h00, 0, 1);
    step("load", 1'b0, 1'b1, 7'b0000011, 3'd2, 7'h55, 0, 0);
    step("store", 1'b0, 1'b1, 7'b0100011, 3'd2, 7'h20, 0, 0);
    step("jal", 1'b0, 1'b1, 7'b1101111, 3'd3, 7'h11, 0, 0);
    step("lui", 1'b0, 1'b1, 7'b0110111, 3'd4, 7'h00, 10, 0);
    step("jalr_001", 1'b0, 1'b1, 7'b1100111, 3'd1, 7'h00, 0, 1);

    step("stall_add", 1'b0, 1'b1, 7'b0110011, 3'd0, 7'h00, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step($sformatf("stall_hold_%0d", i), 1'b0, 1'b0, 7'b0110011, 3'd5, 7'h20, 0, 0);
    end
    step("stall_release", 1'b0, 1'b1, 7'b0110011, 3'd5, 7'h20, 7, 0);
    step("rst_over_stall", 1'b1, 1'b0, 7'b0110011, 3'd5, 7'h20, 0, 0);
    step("unknown_op", 1'b0, 1'b1, 7'h7f, 3'd0, 7'h00, 0, 1);

    for (int i = 0; i < 300; i++) begin
      sel = $urandom_range(0, 11);
      op  = (sel < 9) ? OPS[sel] : 7'($urandom);
      f3  = 3'($urandom);
      sel = $urandom_range(0, 3);
      f7  = (sel == 0) ? 7'h20 : (sel == 1) ? 7'($urandom) : 7'h00;
      step($sformatf("rand_%0d", i), ($urandom_range(0, 29) == 0), ($urandom_range(0, 4) != 0),
           op, f3, f7, -1, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_decoder.md
Name: alu_decoder

Overview:
- Registered ALU-operation decoder for the RV32I single-issue core.
- Takes opcode, func3 and func7 from the instruction word and produces the 4-bit ALU operation select plus an illegal-encoding flag.
- Sits beside the main control decoder and drives the ALU's operation input.
- Outputs are registered on the single core clock.

Parameters:
- none

Ports:
- clk  input  1  core clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- en  input  1  decode enable; when 0, outputs hold (pipeline stall)
- opcode  input  7  instruction bits [6:0]
- func3  input  3  instruction bits [14:12]
- func7  input  7  instruction bits [31:25]
- alu_control  output  4  registered ALU operation select
- illegal  output  1  registered flag: opcode/func combination not a valid ALU-using RV32I encoding

Behaviour:
- ALU codes:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU
  - 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND
  - 10 PASS_B (result = operand 2)
  - 11-15 unused, never produced
- Reset: on a rising clk edge with rst=1, alu_control=0 (ADD) and illegal=0. rst has priority over en.
- Latency: with rst=0 and en=1, the decode of the current inputs appears on the outputs after the next rising edge (1 cycle). With en=0, outputs keep their values.
- OP, 0110011, func7 must be 0000000 or 0100000. Let f7a = func7 = 0100000.
  - func3 000: ADD, or SUB if f7a
  - 001: SLL (f7a illegal)
  - 010: SLT (f7a illegal)
  - 011: SLTU (f7a illegal)
  - 100: XOR (f7a illegal)
  - 101: SRL, or SRA if f7a
  - 110: OR (f7a illegal)
  - 111: AND (f7a illegal)
  - Any other func7 value: illegal.
- OP-IMM, 0010011:
  - func7 ignored except for shifts.
  - 000 ADD, 010 SLT, 011 SLTU, 100 XOR, 110 OR, 111 AND.
  - 001 SLLI: func7 must be 0000000, else illegal.
  - 101: func7=0000000 gives SRL; func7=0100000 gives SRA; else illegal.
- LOAD 0000011, STORE 0100011: ADD (address calc), regardless of func3/func7.
- BRANCH, 1100011:
  - 000/001 (BEQ/BNE): SUB
  - 100/101 (BLT/BGE): SLT
  - 110/111 (BLTU/BGEU): SLTU
  - 010/011: illegal
- JAL 1101111: ADD.
- JALR 1100111: ADD if func3=000, else illegal.
- AUIPC 0010111: ADD.
- LUI 0110111: PASS_B.
- Any other opcode (including SYSTEM/FENCE): illegal.
- Whenever illegal is registered as 1, alu_control is registered as ADD (0).
- Decode is purely a function of the current inputs. No dependence on prior instructions other than the hold under en=0.
- No X propagation: every input combination maps to a defined output pair.

Test Plan:
- Reset: drive rst=1 for 2 edges with opcode=0110011, func3=000, func7=0100000 → alu_control=0, illegal=0. Release rst → after 1 edge alu_control=1 (SUB).
- R-type sweep:
  - opcode 0110011, func7=0000000, func3=000..111 → 0,2,3,4,5,6,8,9, each one cycle after its input.
  - func7=0100000 with func3=000 → 1; func3=101 → 7; func3=110 → illegal=1, alu_control=0.
- I-type shifts: opcode 0010011, func3=101, func7=0100000 → 7. func7=0000000 → 6. func3=001, func7=0100000 → illegal=1, alu_control=0. func3=000, func7=1111111 → 0 (ADDI ignores func7).
- Branch/memory/jump/upper:
  - 1100011/000 → 1; 1100011/100 → 3; 1100011/111 → 4; 1100011/010 → illegal
  - 0000011 → 0; 0100011 → 0; 1101111 → 0; 0110111 → 10
  - 1100111/001 → illegal
- Stall: decode ADD then set en=0 and present an SRA encoding for 3 cycles → alu_control stays 0. Raise en → next edge gives 7.
- Reset mid-stream with en=0 and rst=1 while outputs hold 7 → next edge gives alu_control=0, illegal=0. Unknown opcode 1111111 → illegal=1.
